mem_port_arbiter: RTL and testbench

- Shares the single-port memory interface of `cpu` between the instruction-fetch requester (I) and the load/store requester (D).
- Accepts one request at a time, registers it, issues it to memory with a req/gnt handshake, and routes the response back to the owner.
- Round-robin arbitration on contention; a watchdog terminates stalled memory transactions.
- Sits between the cpu core stages and the memory model instantiated by the testbench.

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (I) and load/store (D).
// One transaction in flight at a time; a watchdog aborts a response that never arrives.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_be,
    input  logic                  m_gnt,
    input  logic                  m_rvalid,
    input  logic [DATA_W-1:0]     m_rdata,
    output logic                  timeout
);
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
    typedef enum logic {SRC_I, SRC_D} src_e;

    state_e                state_q, state_d;
    src_e                  owner_q, owner_d;
    src_e                  last_q, last_d;
    logic                  m_req_q, m_req_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   be_q, be_d;
    logic [15:0]           cnt_q, cnt_d;

    logic sel_i, sel_d, rsp, abort;

    // On contention the requester that did not win last time is selected.
    assign sel_i = i_req && (!d_req || last_q == SRC_D);
    assign sel_d = d_req && (!i_req || last_q == SRC_I);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        m_req_d = m_req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        i_gnt   = 1'b0;
        d_gnt   = 1'b0;
        rsp     = 1'b0;
        abort   = 1'b0;
        if (!rst) begin
            unique case (state_q)
                S_IDLE: begin
                    i_gnt = sel_i;
                    d_gnt = sel_d;
                    if (sel_i) begin
                        owner_d = SRC_I;
                        last_d  = SRC_I;
                        addr_d  = i_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                        be_d    = '1;
                        m_req_d = 1'b1;
                        state_d = S_REQ;
                    end else if (sel_d) begin
                        owner_d = SRC_D;
                        last_d  = SRC_D;
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        be_d    = d_be;
                        m_req_d = 1'b1;
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (m_gnt) begin
                        m_req_d = 1'b0;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response arriving in the watchdog's final cycle still wins.
                    if (m_rvalid) begin
                        rsp     = 1'b1;
                        state_d = S_IDLE;
                    end else if (TIMEOUT != 0 && cnt_q == TIMEOUT_CNT) begin
                        abort   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= SRC_I;
            last_q  <= SRC_D;
            m_req_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            m_req_q <= m_req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = we_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign m_be     = be_q;
    assign timeout  = abort;
    assign i_rvalid = (rsp || abort) && owner_q == SRC_I;
    assign d_rvalid = (rsp || abort) && owner_q == SRC_D;
    assign i_rdata  = (rsp && owner_q == SRC_I) ? m_rdata : '0;
    assign d_rdata  = (rsp && owner_q == SRC_D) ? m_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed transaction table, reset/late-response sequences,
// then randomized traffic checked against a timestamp-based transaction model.
module tb_mem_port_arbiter;
    localparam int TO = 8;

    logic        clk, rst;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        m_req, m_we, m_gnt, m_rvalid, timeout;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
        m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    typedef struct {
        logic        ireq, dreq, we;
        logic [31:0] iaddr, daddr, wdata;
        logic [3:0]  be;
        int          gnt_dly;   // REQ cycles before m_gnt
        int          rsp_dly;   // WAIT cycles before m_rvalid, -1 = never
        logic [31:0] rdata;
        logic        exp_d;     // 1: D must win the grant
        logic        exp_to;    // 1: watchdog abort expected
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v);
        logic fin;
        logic [31:0] ea;
        ea = v.exp_d ? v.daddr : v.iaddr;
        i_req = v.ireq; d_req = v.dreq; i_addr = v.iaddr; d_addr = v.daddr;
        d_we = v.we; d_wdata = v.wdata; d_be = v.be;
        mid();
        chkb("i_gnt", i_gnt, !v.exp_d);
        chkb("d_gnt", d_gnt, v.exp_d);
        tick();
        i_req = 0; d_req = 0;
        for (int k = 0; k <= v.gnt_dly; k++) begin
            m_gnt = (k == v.gnt_dly);
            mid();
            chkb("m_req_hi", m_req, 1'b1);
            chk("m_addr", m_addr, ea);
            chkb("m_we", m_we, v.exp_d && v.we);
            chk("m_be", {28'd0, m_be}, v.exp_d ? {28'd0, v.be} : 32'hF);
            if (v.exp_d && v.we) chk("m_wdata", m_wdata, v.wdata);
            chkb("rvalid_req", i_rvalid | d_rvalid, 1'b0);
            tick();
            m_gnt = 0;
        end
        for (int w = 0; w <= TO; w++) begin
            fin = (w == v.rsp_dly) || (v.rsp_dly < 0 && w == TO);
            m_rvalid = (w == v.rsp_dly);
            m_rdata = v.rdata;
            mid();
            chkb("m_req_wait", m_req, 1'b0);
            chkb("i_rvalid", i_rvalid, fin && !v.exp_d);
            chkb("d_rvalid", d_rvalid, fin && v.exp_d);
            chkb("timeout", timeout, v.exp_to && w == TO);
            if (fin && !v.exp_d) chk("i_rdata", i_rdata, v.exp_to ? 32'h0 : v.rdata);
            if (fin && v.exp_d && !v.we) chk("d_rdata", d_rdata, v.exp_to ? 32'h0 : v.rdata);
            if (v.exp_d) chk("i_rdata_nonowner", i_rdata, 32'h0);
            else         chk("d_rdata_nonowner", d_rdata, 32'h0);
            tick();
            m_rvalid = 0;
            if (fin) break;
        end
    endtask

    // Random-phase reference: one transaction record with timestamps.
    bit          busy, own_d, last_d, mem_granted, win_d;
    bit          exp_ig, exp_dg, done_rsp, done_to;
    int          cyc, t_mgnt, waited;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic        e_we;

    initial begin
        quiet_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        mid();
        chkb("rst_i_gnt", i_gnt, 1'b0);
        chkb("rst_m_req", m_req, 1'b0);
        chk("rst_m_addr", m_addr, 32'h0);
        chkb("rst_timeout", timeout, 1'b0);
        tick();

        vecs[0] = '{1, 1, 0, 32'h0000_1000, 32'h0000_2000, 32'h0, 4'h0, 0, 0, 32'h1111_1111, 0, 0};
        vecs[1] = '{1, 1, 0, 32'h0000_1004, 32'h0000_2004, 32'h0, 4'h0, 0, 0, 32'h2222_2222, 1, 0};
        vecs[2] = '{1, 1, 0, 32'h0000_1008, 32'h0000_2008, 32'h0, 4'h0, 0, 0, 32'h3333_3333, 0, 0};
        vecs[3] = '{1, 1, 0, 32'h0000_100C, 32'h0000_200C, 32'h0, 4'h0, 0, 0, 32'h4444_4444, 1, 0};
        vecs[4] = '{1, 0, 0, 32'h0000_0100, 32'h0,         32'h0, 4'h0, 0, 1, 32'hDEAD_BEEF, 0, 0};
        vecs[5] = '{0, 1, 1, 32'h0,         32'h0000_0020, 32'h1234_5678, 4'b0011, 4, 2, 32'h0, 1, 0};
        vecs[6] = '{0, 1, 0, 32'h0,         32'h0000_0040, 32'h0, 4'hF, 2, 3, 32'hCAFE_F00D, 1, 0};
        vecs[7] = '{1, 0, 0, 32'h0000_0300, 32'h0,         32'h0, 4'h0, 1, -1, 32'h5555_5555, 0, 1};
        vecs[8] = '{1, 1, 0, 32'h0000_0400, 32'h0000_0500, 32'h0, 4'h0, 0, 4, 32'h6666_6666, 1, 0};

        for (int n = 0; n < 8; n++) run_vec(vecs[n]);

        // Late response after the watchdog abort must be ignored.
        m_rvalid = 1; m_rdata = 32'hBAD0_BAD0;
        mid();
        chkb("late_i_rvalid", i_rvalid, 1'b0);
        chkb("late_d_rvalid", d_rvalid, 1'b0);
        chkb("late_timeout", timeout, 1'b0);
        tick();
        m_rvalid = 0;
        run_vec(vecs[8]);

        // Reset while a fetch is waiting for its response.
        i_req = 1; i_addr = 32'h200;
        mid(); chkb("mw_i_gnt", i_gnt, 1'b1);
        tick(); i_req = 0; m_gnt = 1;
        mid(); chkb("mw_m_req", m_req, 1'b1);
        tick(); m_gnt = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        mid();
        chkb("mw_rst_i_gnt", i_gnt, 1'b0);
        chkb("mw_rst_d_gnt", d_gnt, 1'b0);
        chkb("mw_rst_m_req", m_req, 1'b0);
        chkb("mw_rst_m_we", m_we, 1'b0);
        chk("mw_rst_m_addr", m_addr, 32'h0);
        chk("mw_rst_m_wdata", m_wdata, 32'h0);
        chk("mw_rst_m_be", {28'd0, m_be}, 32'h0);
        chkb("mw_rst_rvalid", i_rvalid | d_rvalid, 1'b0);
        chk("mw_rst_rdata", i_rdata | d_rdata, 32'h0);
        chkb("mw_rst_timeout", timeout, 1'b0);
        tick();
        m_rvalid = 1; m_rdata = 32'h7777_7777;
        mid();
        chkb("mw_stale_i_rvalid", i_rvalid, 1'b0);
        chkb("mw_stale_d_rvalid", d_rvalid, 1'b0);
        tick();
        m_rvalid = 0; i_req = 1; d_req = 1;
        mid();
        chkb("mw_cont_i_gnt", i_gnt, 1'b1);
        chkb("mw_cont_d_gnt", d_gnt, 1'b0);
        tick();
        i_req = 0; d_req = 0; m_gnt = 1;
        tick();
        m_gnt = 0; m_rvalid = 1; m_rdata = 32'h8888_8888;
        mid();
        chkb("mw_after_i_rvalid", i_rvalid, 1'b1);
        chk("mw_after_i_rdata", i_rdata, 32'h8888_8888);
        tick();
        quiet_inputs();

        // Randomized traffic against the transaction model.
        rst = 1;
        tick();
        rst = 0;
        busy = 0; last_d = 1; own_d = 0; mem_granted = 0; cyc = 0; t_mgnt = 0;
        e_addr = '0; e_wdata = '0; e_be = '0; e_we = 0;
        for (int c = 0; c < 3000; c++) begin
            i_req   = 1'($urandom_range(0, 1));
            d_req   = 1'($urandom_range(0, 1));
            i_addr  = $urandom;
            d_addr  = $urandom;
            d_we    = 1'($urandom_range(0, 1));
            d_wdata = $urandom;
            d_be    = 4'($urandom);
            m_gnt   = busy && !mem_granted && ($urandom_range(0, 2) == 0);
            m_rvalid = !m_gnt && ($urandom_range(0, 3) == 0);
            m_rdata = $urandom;

            exp_ig = 0; exp_dg = 0; win_d = 0;
            if (!busy && (i_req || d_req)) begin
                win_d = d_req && (!i_req || !last_d);
                exp_ig = !win_d;
                exp_dg = win_d;
            end
            waited   = cyc - t_mgnt - 1;
            done_rsp = busy && mem_granted && m_rvalid;
            done_to  = busy && mem_granted && !m_rvalid && waited == TO;

            mid();
            chkb("r_i_gnt", i_gnt, exp_ig);
            chkb("r_d_gnt", d_gnt, exp_dg);
            chkb("r_m_req", m_req, busy && !mem_granted);
            if (busy && !mem_granted) begin
                chk("r_m_addr", m_addr, e_addr);
                chkb("r_m_we", m_we, e_we);
                chk("r_m_be", {28'd0, m_be}, {28'd0, e_be});
                if (e_we) chk("r_m_wdata", m_wdata, e_wdata);
            end
            chkb("r_i_rvalid", i_rvalid, (done_rsp || done_to) && !own_d);
            chkb("r_d_rvalid", d_rvalid, (done_rsp || done_to) && own_d);
            chkb("r_timeout", timeout, done_to);
            if ((done_rsp || done_to) && !own_d) chk("r_i_rdata", i_rdata, done_rsp ? m_rdata : 32'h0);
            if ((done_rsp || done_to) && own_d && !e_we) chk("r_d_rdata", d_rdata, done_rsp ? m_rdata : 32'h0);
            if (busy && own_d)  chk("r_i_rdata_nonowner", i_rdata, 32'h0);
            if (busy && !own_d) chk("r_d_rdata_nonowner", d_rdata, 32'h0);
            tick();

            if (exp_ig || exp_dg) begin
                busy = 1; own_d = win_d; last_d = win_d; mem_granted = 0;
                e_addr  = win_d ? d_addr : i_addr;
                e_we    = win_d ? d_we : 1'b0;
                e_wdata = d_wdata;
                e_be    = win_d ? d_be : 4'hF;
            end else if (busy && !mem_granted && m_gnt) begin
                mem_granted = 1;
                t_mgnt = cyc;
            end else if (done_rsp || done_to) begin
                busy = 0;
            end
            cyc++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
